// File: rtl/clk_step_ctrl_pkg.sv
// Shared encodings for the run-control / clock-enable scheduler.
package clk_step_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_HALT = 2'b00,
    ST_RUN  = 2'b01,
    ST_STEP = 2'b10
  } state_e;

  typedef enum logic [1:0] {
    MODE_HALT = 2'b00,
    MODE_RUN  = 2'b01
  } mode_e;

  localparam int unsigned MIN_DIVISOR = 2;

endpackage

// File: rtl/clk_period_ctr.sv
// Period counter: counts 0..divisor-1 while enabled, flags the last count
// of each period and produces the registered divided square wave.
module clk_period_ctr
  import clk_step_ctrl_pkg::*;
#(
  parameter int unsigned Width = 28
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             restart,
  input  logic [Width-1:0] divisor,
  output logic             period_end,
  output logic             clk_div
);

  logic [Width-1:0] cnt_q, cnt_d;
  logic             clk_div_q, clk_div_d;

  assign period_end = enable && (cnt_q == divisor - Width'(1));
  assign clk_div    = clk_div_q;

  // Restart is driven at period end by the controller, so the divisor it
  // may swap in at that same edge governs the fresh period from count 0.
  always_comb begin
    cnt_d = cnt_q + Width'(1);
    if (!enable || restart) begin
      cnt_d = '0;
    end
    clk_div_d = enable && (cnt_q < (divisor >> 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      clk_div_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      clk_div_q <= clk_div_d;
    end
  end

endmodule

// File: rtl/clk_step_ctrl.sv
// Run-control FSM (HALT/RUN/STEP), step burst counter and glitch-free
// divisor reconfiguration around the period counter.
module clk_step_ctrl
  import clk_step_ctrl_pkg::*;
#(
  parameter int unsigned Width          = 28,
  parameter int unsigned DefaultDivisor = 50,
  parameter int unsigned StepWidth      = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [1:0]           mode,
  input  logic                 cfg_valid,
  input  logic [Width-1:0]     cfg_divisor,
  output logic                 cfg_ready,
  input  logic                 step_start,
  input  logic [StepWidth-1:0] step_count,
  output logic                 clk_en,
  output logic                 clk_div,
  output logic                 step_done,
  output logic                 cfg_err,
  output logic [1:0]           state
);

  state_e               state_q, state_d;
  logic [StepWidth-1:0] rem_q, rem_d;
  logic [Width-1:0]     div_q, div_d;
  logic [Width-1:0]     pend_q, pend_d;
  logic                 pend_valid_q, pend_valid_d;
  logic                 clk_en_q, clk_en_d;
  logic                 step_done_q, step_done_d;
  logic                 cfg_err_q, cfg_err_d;
  logic                 period_end;

  clk_period_ctr #(
    .Width(Width)
  ) u_period_ctr (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (state_q != ST_HALT),
    .restart   (period_end),
    .divisor   (div_q),
    .period_end(period_end),
    .clk_div   (clk_div)
  );

  assign cfg_ready = !pend_valid_q;
  assign clk_en    = clk_en_q;
  assign step_done = step_done_q;
  assign cfg_err   = cfg_err_q;
  assign state     = state_q;

  always_comb begin
    state_d     = state_q;
    rem_d       = rem_q;
    step_done_d = 1'b0;
    clk_en_d    = period_end;
    unique case (state_q)
      ST_HALT: begin
        if (mode == MODE_RUN) begin
          state_d = ST_RUN;
        end else if (step_start) begin
          if (step_count != '0) begin
            state_d = ST_STEP;
            rem_d   = step_count;
          end else begin
            step_done_d = 1'b1;
          end
        end
      end
      ST_RUN: begin
        if (period_end && (mode != MODE_RUN)) begin
          state_d = ST_HALT;
        end
      end
      ST_STEP: begin
        if (period_end) begin
          rem_d = rem_q - StepWidth'(1);
          if (rem_q == StepWidth'(1)) begin
            state_d     = ST_HALT;
            step_done_d = 1'b1;
          end
        end
      end
      default: state_d = ST_HALT;
    endcase
  end

  // A pending divisor only lands on a period boundary (or while halted), so
  // no running period is ever cut short or stretched.
  always_comb begin
    div_d        = div_q;
    pend_d       = pend_q;
    pend_valid_d = pend_valid_q;
    cfg_err_d    = 1'b0;
    if (pend_valid_q && (period_end || (state_q == ST_HALT))) begin
      div_d        = pend_q;
      pend_valid_d = 1'b0;
    end
    if (cfg_valid && !pend_valid_q) begin
      if (cfg_divisor < Width'(MIN_DIVISOR)) begin
        cfg_err_d = 1'b1;
      end else begin
        pend_d       = cfg_divisor;
        pend_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_HALT;
      rem_q        <= '0;
      div_q        <= Width'(DefaultDivisor);
      pend_q       <= '0;
      pend_valid_q <= 1'b0;
      clk_en_q     <= 1'b0;
      step_done_q  <= 1'b0;
      cfg_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      rem_q        <= rem_d;
      div_q        <= div_d;
      pend_q       <= pend_d;
      pend_valid_q <= pend_valid_d;
      clk_en_q     <= clk_en_d;
      step_done_q  <= step_done_d;
      cfg_err_q    <= cfg_err_d;
    end
  end

endmodule

// File: tb/tb_clk_step_ctrl.sv
// Self-checking bench for clk_step_ctrl: directed scenarios with literal
// expectations plus randomized traffic against a behavioural model.
module tb_clk_step_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  mode;
  logic        cfg_valid;
  logic [27:0] cfg_divisor;
  logic        cfg_ready;
  logic        step_start;
  logic [15:0] step_count;
  logic        clk_en;
  logic        clk_div;
  logic        step_done;
  logic        cfg_err;
  logic [1:0]  state;

  int checks = 0;
  int errors = 0;
  bit checkOn = 1'b0;

  // Model: state 0/1/2, position inside the current period, divisor and
  // pending divisor, bursts left; e* are the registered outputs expected.
  int mState, mPos, mDiv, mPend, mRem;
  bit mPendValid;
  bit eClkEn, eClkDiv, eStepDone, eCfgErr;
  bit mPe, mAccept;
  int mNext;

  clk_step_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .mode       (mode),
    .cfg_valid  (cfg_valid),
    .cfg_divisor(cfg_divisor),
    .cfg_ready  (cfg_ready),
    .step_start (step_start),
    .step_count (step_count),
    .clk_en     (clk_en),
    .clk_div    (clk_div),
    .step_done  (step_done),
    .cfg_err    (cfg_err),
    .state      (state)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mState = 0; mPos = 0; mDiv = 50; mPend = 0; mRem = 0; mPendValid = 0;
      eClkEn = 0; eClkDiv = 0; eStepDone = 0; eCfgErr = 0;
    end else begin
      mPe       = (mState != 0) && (mPos == mDiv - 1);
      mAccept   = cfg_valid && !mPendValid;
      eClkEn    = mPe;
      eClkDiv   = (mState != 0) && (mPos < mDiv / 2);
      eStepDone = 0;
      eCfgErr   = 0;
      mNext     = mState;
      if (mState == 0) begin
        if (mode == 2'b01) mNext = 1;
        else if (step_start) begin
          if (step_count != 0) begin mNext = 2; mRem = int'(step_count); end
          else eStepDone = 1;
        end
      end else if (mState == 1) begin
        if (mPe && mode != 2'b01) mNext = 0;
      end else if (mPe) begin
        mRem = mRem - 1;
        if (mRem == 0) begin mNext = 0; eStepDone = 1; end
      end
      if (mPendValid && (mPe || mState == 0)) begin
        mDiv = mPend;
        mPendValid = 0;
      end
      if (mAccept) begin
        if (int'(cfg_divisor) < 2) eCfgErr = 1;
        else begin mPend = int'(cfg_divisor); mPendValid = 1; end
      end
      mPos   = (mState == 0 || mPe) ? 0 : mPos + 1;
      mState = mNext;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got %0d expected %0d", name, $time, actual, expected);
    end
  endtask

  always @(negedge clk) begin
    if (checkOn) begin
      checkOutput("clk_en", 32'(clk_en), 32'(eClkEn));
      checkOutput("clk_div", 32'(clk_div), 32'(eClkDiv));
      checkOutput("step_done", 32'(step_done), 32'(eStepDone));
      checkOutput("cfg_err", 32'(cfg_err), 32'(eCfgErr));
      checkOutput("state", 32'(state), 32'(mState));
      checkOutput("cfg_ready", 32'(cfg_ready), 32'(!mPendValid));
    end
  end

  task automatic applyStimulus(input logic [1:0] m, input bit cv, input int cd,
                               input bit ss, input int sc);
    mode        = m;
    cfg_valid   = cv;
    cfg_divisor = 28'(cd);
    step_start  = ss;
    step_count  = 16'(sc);
  endtask

  // Counts posedges until clk_en is seen just after an edge.
  task automatic waitClkEn(output int edges);
    edges = 0;
    do begin
      @(posedge clk); #1;
      edges++;
    end while (!clk_en && edges < 500);
    if (!clk_en) begin
      checks++;
      errors++;
      $display("[TB] FAIL wait_clk_en: got no clk_en within %0d cycles", edges);
    end
  endtask

  int n, highs, ens;
  bit doReset;

  initial begin
    rst_n = 1'b1;
    applyStimulus(2'b00, 0, 0, 0, 0);
    #2 rst_n = 1'b0;
    #1 checkOn = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    checkOutput("reset_state", 32'(state), 32'd0);
    checkOutput("reset_cfg_ready", 32'(cfg_ready), 32'd1);

    // RUN at the default divisor of 50
    applyStimulus(2'b01, 0, 0, 0, 0);
    waitClkEn(n);
    checkOutput("first_en_latency", 32'(n), 32'd51);
    checkOutput("run_state", 32'(state), 32'd1);
    highs = 0;
    for (int j = 1; j <= 50; j++) begin
      @(posedge clk); #1;
      highs += int'(clk_div);
      if (j < 50 && clk_en) checkOutput("early_en", 32'(j), 32'd50);
    end
    checkOutput("second_en_gap", 32'(clk_en), 32'd1);
    checkOutput("clk_div_high", 32'(highs), 32'd25);

    // Reprogram to 10 at count 20: current period keeps 50 cycles
    repeat (20) @(posedge clk);
    #1 applyStimulus(2'b01, 1, 10, 0, 0);
    @(posedge clk); #1 applyStimulus(2'b01, 0, 0, 0, 0);
    checkOutput("cfg_ready_pending", 32'(cfg_ready), 32'd0);
    waitClkEn(n);
    checkOutput("period_kept", 32'(n + 21), 32'd50);
    checkOutput("cfg_ready_back", 32'(cfg_ready), 32'd1);
    waitClkEn(n);
    checkOutput("new_period", 32'(n), 32'd10);

    // Rejected divisors
    for (int d = 1; d >= 0; d--) begin
      applyStimulus(2'b01, 1, d, 0, 0);
      @(posedge clk); #1 applyStimulus(2'b01, 0, 0, 0, 0);
      checkOutput("cfg_err_pulse", 32'(cfg_err), 32'd1);
      checkOutput("cfg_err_ready", 32'(cfg_ready), 32'd1);
      @(posedge clk); #1;
      checkOutput("cfg_err_single", 32'(cfg_err), 32'd0);
    end
    waitClkEn(n);
    waitClkEn(n);
    checkOutput("div_unchanged", 32'(n), 32'd10);

    // Leave RUN mid-period: that period's enable still comes
    repeat (5) @(posedge clk);
    #1 applyStimulus(2'b00, 0, 0, 0, 0);
    waitClkEn(n);
    checkOutput("halt_final_en", 32'(n + 5), 32'd10);
    checkOutput("halt_state", 32'(state), 32'd0);
    highs = 0; ens = 0;
    repeat (30) begin
      @(posedge clk); #1;
      highs += int'(clk_div);
      ens   += int'(clk_en);
    end
    checkOutput("halt_no_en", 32'(ens), 32'd0);
    checkOutput("halt_no_div", 32'(highs), 32'd0);

    // Divisor 4 applied while halted, then a 3-enable burst
    applyStimulus(2'b00, 1, 4, 0, 0);
    @(posedge clk); #1 applyStimulus(2'b00, 0, 0, 0, 0);
    checkOutput("halt_cfg_pending", 32'(cfg_ready), 32'd0);
    @(posedge clk); #1;
    checkOutput("halt_cfg_applied", 32'(cfg_ready), 32'd1);
    applyStimulus(2'b00, 0, 0, 1, 3);
    @(posedge clk); #1 applyStimulus(2'b00, 0, 0, 0, 0);
    checkOutput("step_state", 32'(state), 32'd2);
    waitClkEn(n);
    checkOutput("step_first", 32'(n + 1), 32'd5);
    checkOutput("step_done_1", 32'(step_done), 32'd0);
    waitClkEn(n);
    checkOutput("step_gap_2", 32'(n), 32'd4);
    checkOutput("step_done_2", 32'(step_done), 32'd0);
    waitClkEn(n);
    checkOutput("step_gap_3", 32'(n), 32'd4);
    checkOutput("step_done_3", 32'(step_done), 32'd1);
    checkOutput("step_end_state", 32'(state), 32'd0);

    // Zero-length step request
    applyStimulus(2'b00, 0, 0, 1, 0);
    @(posedge clk); #1 applyStimulus(2'b00, 0, 0, 0, 0);
    checkOutput("step_zero_done", 32'(step_done), 32'd1);
    checkOutput("step_zero_state", 32'(state), 32'd0);

    // Reset in the middle of a burst with a divisor change pending
    applyStimulus(2'b00, 0, 0, 1, 3);
    @(posedge clk); #1 applyStimulus(2'b00, 0, 0, 0, 0);
    waitClkEn(n);
    applyStimulus(2'b00, 1, 7, 0, 0);
    @(posedge clk); #1 applyStimulus(2'b00, 0, 0, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rst_state", 32'(state), 32'd0);
    checkOutput("rst_clk_en", 32'(clk_en), 32'd0);
    checkOutput("rst_clk_div", 32'(clk_div), 32'd0);
    checkOutput("rst_step_done", 32'(step_done), 32'd0);
    checkOutput("rst_cfg_ready", 32'(cfg_ready), 32'd1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    applyStimulus(2'b01, 0, 0, 0, 0);
    waitClkEn(n);
    checkOutput("rst_default_div", 32'(n), 32'd51);
    applyStimulus(2'b00, 0, 0, 0, 0);
    waitClkEn(n);

    // Randomized traffic against the model
    doReset = 0;
    for (int c = 0; c < 5000; c++) begin
      @(posedge clk); #1;
      if (doReset) begin
        rst_n = 1'b1;
        doReset = 0;
      end
      applyStimulus(($urandom_range(0, 99) < 3) ? 2'($urandom_range(0, 3)) : mode,
                    $urandom_range(0, 99) < 6, int'($urandom_range(0, 12)),
                    $urandom_range(0, 99) < 5, int'($urandom_range(0, 5)));
      if ($urandom_range(0, 999) < 3) begin
        #2 rst_n = 1'b0;
        doReset = 1;
      end
    end
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/clk_step_ctrl.md
Name: clk_step_ctrl

Overview:
- Run-control and clock-enable scheduler for bring-up of the RISC compute core on FPGA boards.
- Generates a divided clock-enable (and a matching square wave) from the board oscillator.
- Supports HALT / RUN / single- and multi-step modes, and a divisor that can be reprogrammed at runtime without glitches.
- Sits between the board clock and the core's clock-enable input; driven by debug switches or a host debug port.

Parameters:
- Width, 28, bit width of the divisor and the period counter.
- DefaultDivisor, 50, divisor loaded at reset; must be at least 2.
- StepWidth, 16, bit width of the step counter.

Ports:
- Clk  in  1  board clock; all logic on posedge.
- Reset_n  in  1  asynchronous, active-low reset.
- Mode  in  2  00 = HALT, 01 = RUN, 1x = reserved (treated as HALT).
- CfgValid  in  1  new-divisor request.
- CfgDivisor  in  Width  requested divisor.
- CfgReady  out  1  high when no divisor change is pending.
- StepStart  in  1  one-cycle request to issue StepCount enables.
- StepCount  in  StepWidth  number of enables for a step burst.
- ClkEn  out  1  one-cycle clock-enable pulse per divided period.
- ClkDiv  out  1  registered square wave, high while counter < Divisor/2.
- StepDone  out  1  one-cycle pulse when a step burst completes.
- CfgErr  out  1  one-cycle pulse when a divisor request is rejected.
- State  out  2  00 = HALT, 01 = RUN, 10 = STEP.

Behaviour:
- Reset (asynchronous, Reset_n low):
  - counter = 0, active divisor = DefaultDivisor, no divisor pending, state = HALT.
  - ClkEn, ClkDiv, StepDone and CfgErr are 0; CfgReady is 1.
- Period counter:
  - In RUN or STEP, counts 0 .. Div-1 and wraps to 0.
  - In HALT, held at 0.
  - "Period end" means counter == Div-1 in RUN or STEP.
- ClkEn: registered; high for exactly 1 cycle, in the cycle after each period end where an enable is issued. Never high in HALT.
- ClkDiv: registered from (counter < Div/2) while in RUN or STEP; 0 in HALT.
  - Duty cycle is floor(Div/2)/Div.
- Divisor reconfiguration:
  - A request is accepted when CfgValid && CfgReady.
  - If CfgDivisor < 2: rejected, CfgErr pulses next cycle, CfgReady stays 1.
  - Otherwise the value goes into the pending register and CfgReady drops to 0.
  - A pending value is applied at the next period end (counter restarts at 0 with the new divisor), or on the next cycle if the state is HALT.
  - CfgReady returns to 1 in the cycle after the value is applied.
  - A period in progress is never truncated or stretched.
- State machine:
  - HALT -> RUN: when Mode == 01, the counter starts at 0; first ClkEn comes Div cycles later.
  - HALT -> STEP: when StepStart && StepCount != 0 (and Mode != 01); load remaining = StepCount.
  - StepStart with StepCount == 0 in HALT: StepDone pulses next cycle; state stays HALT.
  - RUN -> HALT: Mode is sampled at period end. If Mode != 01, that period's ClkEn is still issued, then the state goes to HALT.
  - STEP: each period end issues ClkEn and decrements remaining. When remaining reaches 0, go to HALT and pulse StepDone in the same cycle as the final ClkEn.
  - In STEP, Mode and StepStart are ignored (no abort, no re-arm).
  - StepStart in RUN is ignored.
- Simultaneous events:
  - If StepStart and Mode == 01 arrive together in HALT, RUN wins.
  - If a divisor change and a mode change take effect at the same period end, the new divisor applies to the first period of the new state.
- Reset asserted mid-period or mid-burst: immediate return to reset values; the pending divisor and the step count are discarded.

Decomposition:
- Shared package holds:
  - State encodings HALT / RUN / STEP.
  - Mode encodings.
  - The minimum divisor constant (2).
- Sub-module: clk_period_ctr. It holds the counter, the period-end flag and ClkDiv generation, with inputs enable, divisor and restart.
- Controller FSM, step counter and config holding register live in the top level.

Test Plan:
- Reset, then Mode = 01, Divisor = 50 -> first ClkEn 51 cycles after Mode rises; ClkEn every 50 cycles; ClkDiv high 25 / low 25; State = 01.
- HALT, StepCount = 3, StepStart pulse, Div = 4 -> exactly 3 ClkEn pulses 4 cycles apart; StepDone coincident with the third; State returns to 00.
- RUN with Div = 50, CfgDivisor = 10 at counter = 20 -> CfgReady low until the period end; that period stays 50 cycles; subsequent ClkEn every 10 cycles.
- CfgDivisor = 1 or 0 with CfgValid -> CfgErr single pulse; divisor unchanged; CfgReady stays 1.
- RUN, Mode -> 00 at counter = 5 -> the pending period's ClkEn is still issued, then HALT: no further ClkEn, ClkDiv = 0.
- Reset_n low during a STEP burst with remaining = 2 -> outputs at reset values immediately; no StepDone; after release, State = 00 and the divisor is back to 50.
